// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state encoding, lamp bundle, default timing and lamp decode for the phase scheduler
// Contents: tlc_state_e (PHASE encoding), tlc_lamps_t (six lamp bits), *_D default timings, lamps_of().
package tlc_pkg;
    typedef enum logic [2:0] {
        AR_INIT = 3'd0,
        G1      = 3'd1,
        Y1      = 3'd2,
        AR1     = 3'd3,
        G2      = 3'd4,
        Y2      = 3'd5,
        AR2     = 3'd6,
        FLASH   = 3'd7
    } tlc_state_e;
    typedef struct packed {
        logic grn1;
        logic ylw1;
        logic red1;
        logic grn2;
        logic ylw2;
        logic red2;
    } tlc_lamps_t;
    localparam int MIN_GRN_D  = 8;
    localparam int MAX_GRN_D  = 24;
    localparam int YLW_T_D    = 3;
    localparam int ALLRED_T_D = 1;
    localparam int TW_D       = 5;
    // Moore decode: lamps depend only on the registered state and the flash phase bit.
    function automatic tlc_lamps_t lamps_of(tlc_state_e s, logic flash_on);
        tlc_lamps_t l;
        l.grn1 = s == G1;
        l.ylw1 = (s == Y1) || (s == FLASH && flash_on);
        l.red1 = (s == AR_INIT) || (s == AR1) || (s == AR2) || (s == G2) || (s == Y2);
        l.grn2 = s == G2;
        l.ylw2 = (s == Y2) || (s == FLASH && flash_on);
        l.red2 = (s == AR_INIT) || (s == AR1) || (s == AR2) || (s == G1) || (s == Y1);
        return l;
    endfunction
endpackage

// File: rtl/tlc_phase_scheduler_if.sv
// tlc_phase_scheduler_if: request inputs and lamp/phase outputs of the phase scheduler
// Signals: tick, test, fm, req1, req2 (controller -> scheduler); grn/ylw/red 1/2, phase (scheduler -> latches).
// With TLC_PED_EN defined: pb (pedestrian button) in, walk out.
interface tlc_phase_scheduler_if;
    logic       tick;
    logic       test;
    logic       fm;
    logic       req1;
    logic       req2;
    logic       grn1;
    logic       ylw1;
    logic       red1;
    logic       grn2;
    logic       ylw2;
    logic       red2;
    logic [2:0] phase;
`ifdef TLC_PED_EN
    logic       pb;
    logic       walk;
    modport master (output tick, test, fm, req1, req2, pb,
                    input grn1, ylw1, red1, grn2, ylw2, red2, phase, walk);
    modport slave  (input tick, test, fm, req1, req2, pb,
                    output grn1, ylw1, red1, grn2, ylw2, red2, phase, walk);
`else
    modport master (output tick, test, fm, req1, req2,
                    input grn1, ylw1, red1, grn2, ylw2, red2, phase);
    modport slave  (input tick, test, fm, req1, req2,
                    output grn1, ylw1, red1, grn2, ylw2, red2, phase);
`endif
endinterface

// File: rtl/tlc_dwell_timer.sv
// tlc_dwell_timer: saturating TW-bit dwell counter with phase threshold compares
// Ports: i_ck clock; i_clr sync reset; i_sclr clear (state change); i_en effective tick;
//        o_ge_min/o_ge_max/o_ge_ylw/o_ge_ar: dwell at or above each threshold.
module tlc_dwell_timer
    import tlc_pkg::*;
#(
    parameter int TW       = TW_D,
    parameter int MIN_GRN  = MIN_GRN_D,
    parameter int MAX_GRN  = MAX_GRN_D,
    parameter int YLW_T    = YLW_T_D,
    parameter int ALLRED_T = ALLRED_T_D
) (
    input  logic i_ck,
    input  logic i_clr,
    input  logic i_sclr,
    input  logic i_en,
    output logic o_ge_min,
    output logic o_ge_max,
    output logic o_ge_ylw,
    output logic o_ge_ar
);
    // A minimum above the maximum would never be reached first, so the maximum governs.
    localparam int MIN_EFF = (MIN_GRN >= MAX_GRN) ? MAX_GRN : MIN_GRN;
    if (((1 << TW) - 1) < MAX_GRN) begin : g_tw_chk
        $error("tlc_dwell_timer: TW too narrow to reach MAX_GRN");
    end
    logic [TW-1:0] r_d;
    always_ff @(posedge i_ck) begin
        if (i_clr || i_sclr) r_d <= '0;
        else if (i_en && r_d != '1) r_d <= r_d + 1'b1;
    end
    assign o_ge_min = int'(r_d) >= MIN_EFF;
    assign o_ge_max = int'(r_d) >= MAX_GRN;
    assign o_ge_ylw = int'(r_d) >= YLW_T;
    assign o_ge_ar  = int'(r_d) >= ALLRED_T;
endmodule

// File: rtl/tlc_phase_scheduler.sv
// tlc_phase_scheduler: two-approach intersection phase scheduler (calls, min/max green, yellow, all-red, flash)
// Ports: i_ck clock; i_clr sync active-high reset; bus (tlc_phase_scheduler_if.slave): tick/test/fm/req1/req2 in,
//        six lamps and 3-bit phase out. Optional macro TLC_PED_EN adds bus.pb (pedestrian call on approach 2)
//        and bus.walk.
module tlc_phase_scheduler
    import tlc_pkg::*;
#(
    parameter int MIN_GRN  = MIN_GRN_D,
    parameter int MAX_GRN  = MAX_GRN_D,
    parameter int YLW_T    = YLW_T_D,
    parameter int ALLRED_T = ALLRED_T_D,
    parameter int TW       = TW_D
) (
    input logic                  i_ck,
    input logic                  i_clr,
    tlc_phase_scheduler_if.slave bus
);
    tlc_state_e r_state;
    tlc_state_e w_next;
    logic       r_call1;
    logic       r_call2;
    logic       r_flash;
    logic       w_tick;
    logic       w_chg;
    logic       w_ge_min;
    logic       w_ge_max;
    logic       w_ge_ylw;
    logic       w_ge_ar;
    logic       w_call2_any;
    logic       w_g2_fm_ok;
    tlc_lamps_t w_lamps;
    assign w_tick = bus.tick | bus.test;
    assign w_chg  = w_next != r_state;
`ifdef TLC_PED_EN
    logic r_pcall;
    logic r_walk_arm;
    assign w_call2_any = r_call2 | r_pcall;
    // A flash request must not cut a green that may be carrying a pedestrian crossing.
    assign w_g2_fm_ok  = w_ge_min;
    always_ff @(posedge i_ck) begin
        if (i_clr) begin
            r_pcall    <= 1'b0;
            r_walk_arm <= 1'b0;
        end else begin
            r_pcall    <= (w_next == G2 && w_chg) ? 1'b0 : r_pcall | bus.pb;
            r_walk_arm <= (w_next == G2 && w_chg) ? r_pcall : r_walk_arm;
        end
    end
    assign bus.walk = (r_state == G2) && r_walk_arm && !w_ge_min;
`else
    assign w_call2_any = r_call2;
    assign w_g2_fm_ok  = 1'b1;
`endif
    tlc_dwell_timer #(
        .TW       (TW),
        .MIN_GRN  (MIN_GRN),
        .MAX_GRN  (MAX_GRN),
        .YLW_T    (YLW_T),
        .ALLRED_T (ALLRED_T)
    ) u_dwell (
        .i_ck     (i_ck),
        .i_clr    (i_clr),
        .i_sclr   (w_chg),
        .i_en     (w_tick),
        .o_ge_min (w_ge_min),
        .o_ge_max (w_ge_max),
        .o_ge_ylw (w_ge_ylw),
        .o_ge_ar  (w_ge_ar)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            AR_INIT: w_next = w_ge_ar ? G1 : AR_INIT;
            G1: begin
                if (bus.fm || (w_call2_any && ((w_ge_min && !bus.req1) || w_ge_max))) w_next = Y1;
            end
            Y1:  w_next = w_ge_ylw ? AR1 : Y1;
            AR1: w_next = w_ge_ar ? (bus.fm ? FLASH : G2) : AR1;
            G2: begin
                if ((bus.fm && w_g2_fm_ok) || (r_call1 && ((w_ge_min && !bus.req2) || w_ge_max))) w_next = Y2;
            end
            Y2:    w_next = w_ge_ylw ? AR2 : Y2;
            AR2:   w_next = w_ge_ar ? (bus.fm ? FLASH : G1) : AR2;
            FLASH: w_next = bus.fm ? FLASH : AR_INIT;
            default: w_next = AR_INIT;
        endcase
    end
    // Calls are cleared on the edge that grants the green, even if the sensor is still high.
    always_ff @(posedge i_ck) begin
        if (i_clr) begin
            r_state <= AR_INIT;
            r_call1 <= 1'b0;
            r_call2 <= 1'b0;
            r_flash <= 1'b0;
        end else begin
            r_state <= w_next;
            r_call1 <= (w_next == G1 && w_chg) ? 1'b0 : r_call1 | bus.req1;
            r_call2 <= (w_next == G2 && w_chg) ? 1'b0 : r_call2 | bus.req2;
            r_flash <= (w_next == FLASH && w_chg) ? 1'b1 : r_flash ^ (r_state == FLASH && w_tick);
        end
    end
    assign w_lamps   = lamps_of(r_state, r_flash);
    assign bus.grn1  = w_lamps.grn1;
    assign bus.ylw1  = w_lamps.ylw1;
    assign bus.red1  = w_lamps.red1;
    assign bus.grn2  = w_lamps.grn2;
    assign bus.ylw2  = w_lamps.ylw2;
    assign bus.red2  = w_lamps.red2;
    assign bus.phase = r_state;
endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// tb_tlc_phase_scheduler: scoreboard bench; stimulus queues expected phase events, a monitor checks them
module tb_tlc_phase_scheduler;
    import tlc_pkg::*;
    localparam logic [5:0] L_G1 = 6'b100001;
    localparam logic [5:0] L_Y1 = 6'b010001;
    localparam logic [5:0] L_AR = 6'b001001;
    localparam logic [5:0] L_G2 = 6'b001100;
    localparam logic [5:0] L_Y2 = 6'b001010;
    localparam logic [5:0] L_FY = 6'b010010;
    localparam logic [5:0] L_FO = 6'b000000;
    typedef struct {
        string      nm;
        logic [2:0] ph;
        logic [5:0] lm;
        int         dur;
    } exp_t;
    exp_t       q[$];
    exp_t       e;
    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       sreq = 1'b0;
    int         checks = 0;
    int         passes = 0;
    int         cnt = 0;
    logic [2:0] prev = '0;
    logic [5:0] lm;
    tlc_phase_scheduler_if bus();
    tlc_phase_scheduler dut (.i_ck(clk), .i_clr(clr), .bus(bus));
    always #5 clk = ~clk;
    assign lm = {bus.grn1, bus.ylw1, bus.red1, bus.grn2, bus.ylw2, bus.red2};
    task automatic push(input string n, input logic [2:0] p, input logic [5:0] l, input int d);
        q.push_back('{n, p, l, d});
    endtask
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic sample(input string n, input logic [2:0] p, input logic [5:0] l);
        push(n, p, l, -1);
        sreq = 1'b1;
        @(negedge clk);
        #1 sreq = 1'b0;
    endtask
    task automatic wait_phase(input logic [2:0] p);
        int n = 0;
        while (bus.phase !== p && n < 300) begin
            cyc(1);
            n++;
        end
        checks++;
        if (bus.phase === p) passes++;
        else $display("FAIL wait_phase: phase=%0d, required %0d within 300 cycles", bus.phase, p);
    endtask
    task automatic pulse(input int a);
        if (a == 1) bus.req1 = 1'b1; else bus.req2 = 1'b1;
        cyc(1);
        bus.req1 = 1'b0;
        bus.req2 = 1'b0;
    endtask
    // Monitor: an event is a phase change or an explicit sample request; dur = cycles spent in the previous phase.
    initial forever begin
        @(negedge clk);
        if (clr) begin
            prev = bus.phase;
            cnt = 0;
        end else begin
            if (bus.phase != prev || sreq) begin
                checks++;
                if (q.size() == 0) begin
                    $display("FAIL unexpected_event: phase=%0d lamps=%b, required no change", bus.phase, lm);
                end else begin
                    e = q.pop_front();
                    if (bus.phase === e.ph && lm === e.lm && (e.dur < 0 || cnt + 1 == e.dur)) passes++;
                    else $display("FAIL %s: phase=%0d lamps=%b dur=%0d, required phase=%0d lamps=%b dur=%0d",
                                  e.nm, bus.phase, lm, cnt + 1, e.ph, e.lm, e.dur);
                end
                prev = bus.phase;
                cnt = 0;
            end else cnt++;
            checks++;
            if ((bus.grn1 && bus.grn2) || (bus.grn1 && bus.ylw2) || (bus.ylw1 && bus.grn2) ||
                (bus.phase != 3'(FLASH) && (!(bus.grn1 | bus.ylw1 | bus.red1) || !(bus.grn2 | bus.ylw2 | bus.red2))))
                $display("FAIL safety: lamps=%b phase=%0d, required no conflict and a lit lamp per approach", lm, bus.phase);
            else passes++;
        end
    end
    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end
    initial begin
        bus.tick = 1'b0;
        bus.test = 1'b1;
        bus.fm   = 1'b0;
        bus.req1 = 1'b0;
        bus.req2 = 1'b0;
`ifdef TLC_PED_EN
        bus.pb = 1'b0;
`endif
        cyc(2);
        clr = 1'b0;
        sample("reset", AR_INIT, L_AR);
        push("init_to_g1", G1, L_G1, 2);
        wait_phase(G1);
        pulse(2);
        push("g1_min_exit", Y1, L_Y1, 9);
        push("y1_dwell", AR1, L_AR, 4);
        push("ar1_to_g2", G2, L_G2, 2);
        wait_phase(G2);
        pulse(1);
        push("g2_min_exit", Y2, L_Y2, 9);
        push("y2_dwell", AR2, L_AR, 4);
        push("ar2_to_g1", G1, L_G1, 2);
        wait_phase(G1);
        cyc(40);
        sample("g1_rests_call2_cleared", G1, L_G1);
        bus.req1 = 1'b1;
        bus.req2 = 1'b1;
        push("g1_sat_exit", Y1, L_Y1, -1);
        push("alt_y1", AR1, L_AR, 4);
        push("alt_ar1", G2, L_G2, 2);
        push("g2_max", Y2, L_Y2, 25);
        push("alt_y2", AR2, L_AR, 4);
        push("alt_ar2", G1, L_G1, 2);
        push("g1_max", Y1, L_Y1, 25);
        push("alt_y1b", AR1, L_AR, 4);
        push("alt_ar1b", G2, L_G2, 2);
        push("g2_max_b", Y2, L_Y2, 25);
        push("alt_y2b", AR2, L_AR, 4);
        push("alt_ar2b", G1, L_G1, 2);
        wait_phase(G2);
        wait_phase(G1);
        wait_phase(G2);
        wait_phase(AR2);
        bus.req1 = 1'b0;
        bus.req2 = 1'b0;
        push("fm_cuts_g1", Y1, L_Y1, 3);
        push("fm_y1_full", AR1, L_AR, 4);
        push("fm_to_flash", FLASH, L_FY, 2);
        wait_phase(G1);
        cyc(2);
        bus.fm = 1'b1;
        wait_phase(FLASH);
        cyc(1);
        sample("flash_off", FLASH, L_FO);
        cyc(1);
        sample("flash_on", FLASH, L_FY);
        push("flash_exit", AR_INIT, L_AR, -1);
        push("flash_init_g1", G1, L_G1, 2);
        push("pending_call2", Y1, L_Y1, 9);
        push("pend_y1", AR1, L_AR, 4);
        push("pend_ar1", G2, L_G2, 2);
        bus.fm = 1'b0;
        wait_phase(G2);
        pulse(1);
        push("g2_exit_again", Y2, L_Y2, 9);
        wait_phase(Y2);
        bus.req2 = 1'b1;
        cyc(1);
        bus.req2 = 1'b0;
        clr = 1'b1;
        push("clr_mid_y2", AR_INIT, L_AR, -1);
        push("clr_to_g1", G1, L_G1, 2);
        cyc(1);
        clr = 1'b0;
        wait_phase(G1);
        cyc(20);
        sample("clr_cleared_calls", G1, L_G1);
        bus.test = 1'b0;
        push("tick_g1_exit", Y1, L_Y1, -1);
        push("tick_y1_dwell", AR1, L_AR, 13);
        pulse(2);
        wait_phase(Y1);
        repeat (3) begin
            cyc(3);
            bus.tick = 1'b1;
            cyc(1);
            bus.tick = 1'b0;
        end
        wait_phase(AR1);
        cyc(10);
        sample("ar1_waits_for_tick", AR1, L_AR);
        push("test_resume", G2, L_G2, -1);
        bus.test = 1'b1;
        cyc(10);
        checks++;
        if (q.size() == 0) passes++;
        else $display("FAIL queue_drained: %0d events pending, required 0", q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
